// File: rtl/rv_pkg.sv
// Shared RV32 constants and fetch-stage types.
// Imported by the fetch stage and the control decoder.
package rv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction memory request/response channel.
// Request is valid/ready; response has no backpressure.
interface if_fetch_if #(
    parameter int XLEN = 32
);

    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/if_out_buf.sv
// One-entry instruction/PC holding register for decode.
// Flush dominates load; consume clears valid but keeps data.
module if_out_buf
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [XLEN-1:0] load_instr,
    input  logic [XLEN-1:0] load_pc,
    input  logic            consume,
    input  logic            flush,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (consume) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            instr_d = load_instr;
            pc_d    = load_pc;
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= XLEN'(NOP_INSTR);
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, keeps one request in flight,
// and drops stale responses after an execute redirect.
module if_fetch
    import rv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    if_fetch_if.master      imem,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [6:0]      id_opcode
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

    logic req_valid;
    logic req_fire;
    logic buf_load;
    logic buf_consume;

    // Only issue when the buffer is free or being drained this cycle.
    assign req_valid = rst_n
                     && (state_q == S_REQ)
                     && !redirect_valid
                     && (!id_valid || id_ready);
    assign req_fire  = req_valid && imem.req_ready;

    assign imem.req_valid = req_valid;
    assign imem.req_addr  = pc_q;

    assign buf_consume = id_valid && id_ready;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        buf_load      = 1'b0;
        if (redirect_valid) begin
            pc_d = redirect_pc & ALIGN_MASK;
            if (state_q != S_REQ) begin
                state_d = imem.rsp_valid ? S_REQ : S_DROP;
            end
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (req_fire) begin
                        state_d       = S_WAIT;
                        inflight_pc_d = pc_q;
                        pc_d          = pc_q + XLEN'(4);
                    end
                end
                S_WAIT: begin
                    if (imem.rsp_valid) begin
                        state_d  = S_REQ;
                        buf_load = 1'b1;
                    end
                end
                S_DROP: begin
                    if (imem.rsp_valid) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    if_out_buf #(
        .XLEN (XLEN)
    ) u_out_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (buf_load),
        .load_instr (imem.rsp_data),
        .load_pc    (inflight_pc_q),
        .consume    (buf_consume),
        .flush      (redirect_valid),
        .valid      (id_valid),
        .instr      (id_instr),
        .pc         (id_pc)
    );

    assign id_opcode = id_instr[6:0];

    // A response may only land in an empty buffer.
    a_load_empty: assert property (
        @(posedge clk) disable iff (!rst_n) buf_load |-> !id_valid
    );

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a transaction-level reference model.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;

    logic        w_id_valid;
    logic [31:0] w_id_instr;
    logic [31:0] w_id_pc;
    logic [6:0]  w_id_opcode;

    if_fetch_if #(.XLEN(32)) imem ();
    if_fetch_if #(.XLEN(32)) wmem ();

    always #5 clk = ~clk;

    if_fetch #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (imem),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_opcode      (id_opcode)
    );

    if_fetch #(
        .XLEN     (32),
        .RESET_PC (32'hFFFF_FFFC)
    ) dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (wmem),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .id_valid       (w_id_valid),
        .id_ready       (1'b1),
        .id_instr       (w_id_instr),
        .id_pc          (w_id_pc),
        .id_opcode      (w_id_opcode)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    logic [31:0] req_log[$];
    logic [31:0] w_log[$];
    logic [31:0] cons_pc[$];
    logic [31:0] cons_in[$];

    int          lat = 1;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0033;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: next fetch PC, one outstanding slot, one buffer slot.
    logic        m_out = 1'b0;
    logic        m_stale = 1'b0;
    logic [31:0] m_opc = '0;
    logic [31:0] m_pc = '0;
    logic        m_bv = 1'b0;
    logic [31:0] m_bi = 32'h0000_0013;
    logic [31:0] m_bp = '0;

    function automatic logic exp_req(input logic rn, input logic rd,
                                     input logic rdy);
        return rn && !m_out && !rd && (!m_bv || rdy);
    endfunction

    always @(posedge clk) begin : model
        logic        o, s, bv;
        logic [31:0] p, op, bi, bp;
        logic        fire;
        o = m_out; s = m_stale; p = m_pc; op = m_opc;
        bv = m_bv; bi = m_bi; bp = m_bp;
        fire = exp_req(rst_n, redirect_valid, id_ready) && imem.req_ready;
        if (!rst_n) begin
            o = 1'b0; s = 1'b0; p = 32'h0; bv = 1'b0;
            bi = 32'h0000_0013; bp = 32'h0;
        end else if (redirect_valid) begin
            p = {redirect_pc[31:2], 2'b00};
            bv = 1'b0;
            if (o && imem.rsp_valid) begin
                o = 1'b0; s = 1'b0;
            end else if (o) begin
                s = 1'b1;
            end
        end else begin
            if (bv && id_ready) bv = 1'b0;
            if (o && imem.rsp_valid) begin
                if (!s) begin
                    bv = 1'b1; bi = imem.rsp_data; bp = op;
                end
                o = 1'b0; s = 1'b0;
            end else if (fire) begin
                o = 1'b1; s = 1'b0; op = p; p = p + 32'd4;
            end
        end
        m_out <= o; m_stale <= s; m_pc <= p; m_opc <= op;
        m_bv <= bv; m_bi <= bi; m_bp <= bp;
    end

    always @(negedge clk) begin : compare
        logic erv;
        if (chk_en) begin
            erv = exp_req(rst_n, redirect_valid, id_ready);
            chk("req_valid", 32'(imem.req_valid), 32'(erv));
            if (erv) chk("req_addr", imem.req_addr, m_pc);
            chk("id_valid", 32'(id_valid), 32'(m_bv));
            chk("id_instr", id_instr, m_bi);
            chk("id_pc", id_pc, m_bp);
            chk("id_opcode", 32'(id_opcode), 32'(m_bi[6:0]));
        end
    end

    task automatic step();
        logic        hs, whs;
        logic [31:0] ha, wha;
        @(negedge clk);
        hs  = imem.req_valid && imem.req_ready;
        ha  = imem.req_addr;
        whs = wmem.req_valid && wmem.req_ready;
        wha = wmem.req_addr;
        if (id_valid && id_ready && !redirect_valid && rst_n) begin
            cons_pc.push_back(id_pc);
            cons_in.push_back(id_instr);
        end
        @(posedge clk);
        #1;
        if (hs) begin
            req_log.push_back(ha);
            pend = 1'b1; paddr = ha; cnt = lat;
        end
        imem.rsp_valid = 1'b0;
        if (pend) begin
            if (cnt <= 1) begin
                imem.rsp_valid = 1'b1;
                imem.rsp_data  = instr_of(paddr);
                pend = 1'b0;
            end else begin
                cnt--;
            end
        end
        wmem.rsp_valid = whs;
        wmem.rsp_data  = instr_of(wha);
        if (whs) w_log.push_back(wha);
    endtask

    task automatic wait_req(input string nm);
        int n0;
        int k;
        n0 = req_log.size();
        k = 0;
        while (req_log.size() == n0 && k < 20) begin
            step();
            k++;
        end
        if (req_log.size() == n0) begin
            tests++;
            fails++;
            $display("FAIL %s: no request within 20 cycles", nm);
        end
    endtask

    int n;
    int nc;

    initial begin
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b1;
        imem.req_ready = 1'b1;
        imem.rsp_valid = 1'b0;
        imem.rsp_data = '0;
        wmem.req_ready = 1'b1;
        wmem.rsp_valid = 1'b0;
        wmem.rsp_data = '0;

        step();
        chk_en = 1'b1;
        step();
        chk("rst_id_valid", 32'(id_valid), 32'h0);
        chk("rst_id_instr", id_instr, 32'h0000_0013);
        chk("rst_req_valid", 32'(imem.req_valid), 32'h0);
        rst_n = 1'b1;

        // Streaming fetch, 1-cycle memory.
        wait_req("seq0");
        wait_req("seq1");
        wait_req("seq2");
        repeat (3) step();
        chk("seq_req0", req_log[0], 32'h0);
        chk("seq_req1", req_log[1], 32'h4);
        chk("seq_req2", req_log[2], 32'h8);
        chk("seq_pc0", cons_pc[0], 32'h0);
        chk("seq_pc1", cons_pc[1], 32'h4);
        chk("seq_pc2", cons_pc[2], 32'h8);
        chk("seq_in0", cons_in[0], 32'hA5A5_0033);
        chk("seq_in2", cons_in[2], 32'hA5A5_003B);

        // Decode stall holds the buffer and blocks new requests.
        id_ready = 1'b0;
        repeat (2) step();
        n = req_log.size();
        repeat (3) step();
        chk("stall_nreq", 32'(req_log.size()), 32'(n));
        chk("stall_pc", id_pc, 32'hC);
        id_ready = 1'b1;
        n = req_log.size();
        wait_req("unstall");
        chk("unstall_addr", req_log[n], 32'h10);

        // Spurious response while idle in S_REQ is ignored.
        imem.req_ready = 1'b0;
        repeat (4) step();
        imem.rsp_valid = 1'b1;
        imem.rsp_data = 32'hDEAD_BEEF;
        step();
        chk("spur_valid", 32'(id_valid), 32'h0);
        imem.req_ready = 1'b1;
        n = req_log.size();
        wait_req("after_spur");
        chk("after_spur_addr", req_log[n], 32'h14);

        // Redirect in S_WAIT coinciding with the response.
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        step();
        redirect_valid = 1'b0;
        chk("rdw_flush", 32'(id_valid), 32'h0);
        lat = 3;
        n = req_log.size();
        wait_req("rdw");
        chk("rdw_addr", req_log[n], 32'h300);

        // Redirect in S_WAIT, response three cycles after acceptance.
        nc = cons_pc.size();
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        step();
        redirect_valid = 1'b0;
        lat = 4;
        n = req_log.size();
        wait_req("drop");
        chk("drop_addr", req_log[n], 32'h100);
        chk("drop_ncons", 32'(cons_pc.size()), 32'(nc));

        // Two redirects while the stale response is outstanding.
        redirect_valid = 1'b1;
        redirect_pc = 32'h400;
        step();
        redirect_pc = 32'h500;
        step();
        redirect_valid = 1'b0;
        lat = 2;
        n = req_log.size();
        wait_req("dbl");
        chk("dbl_addr", req_log[n], 32'h500);

        // Redirect in S_DROP on the same cycle the stale response lands.
        redirect_valid = 1'b1;
        redirect_pc = 32'h600;
        step();
        redirect_pc = 32'h700;
        step();
        redirect_valid = 1'b0;
        lat = 2;
        n = req_log.size();
        wait_req("droprd");
        chk("droprd_addr", req_log[n], 32'h700);

        // Reset while waiting; the response lands during reset.
        rst_n = 1'b0;
        step();
        step();
        chk("mid_rst_valid", 32'(id_valid), 32'h0);
        rst_n = 1'b1;
        lat = 1;
        n = req_log.size();
        wait_req("post_rst");
        chk("post_rst_addr", req_log[n], 32'h0);

        // Full buffer, spurious response and redirect together.
        id_ready = 1'b0;
        repeat (3) step();
        chk("full_valid", 32'(id_valid), 32'h1);
        chk("full_pc", id_pc, 32'h0);
        imem.rsp_valid = 1'b1;
        imem.rsp_data = 32'hDEAD_BEEF;
        redirect_valid = 1'b1;
        redirect_pc = 32'h202;
        step();
        redirect_valid = 1'b0;
        chk("full_flush", 32'(id_valid), 32'h0);
        id_ready = 1'b1;
        n = req_log.size();
        wait_req("full_rd");
        chk("full_rd_addr", req_log[n], 32'h200);
        repeat (4) step();

        // Wrap-around instance.
        chk("wrap0", w_log[0], 32'hFFFF_FFFC);
        chk("wrap1", w_log[1], 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
